// File: rtl/safe_pkg.sv
// Shared key codes, FSM state encoding and key classification for the safe lock controller.
package safe_pkg;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam logic [3:0] KEY_NONE  = 4'd13;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StEntry    = 3'd1,
    StCheck    = 3'd2,
    StUnlocked = 3'd3,
    StProgram  = 3'd4,
    StLockout  = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_entry_buffer.sv
// PIN digit collector: nibble shift register, digit count and overflow flag.
// Newest digit lands in the LS nibble, so the first-entered digit ends up in the MS nibble.
module keypad_entry_buffer #(
  parameter int unsigned CODE_LEN = 4,
  localparam int unsigned CntW = $clog2(CODE_LEN + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [3:0]            digit_i,
  output logic [4*CODE_LEN-1:0] buf_o,
  output logic [CntW-1:0]       count_o,
  output logic                  overflow_o
);

  logic [4*CODE_LEN-1:0] buf_q, buf_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  // Clear has priority; a digit past CODE_LEN only flags overflow and leaves the buffer intact.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_i) begin
      if (cnt_q < CntW'(CODE_LEN)) begin
        buf_d      = buf_q << 4;
        buf_d[3:0] = digit_i;
        cnt_d      = cnt_q + CntW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign buf_o      = buf_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/safe_lock_controller.sv
// Safe unlock sequencer: PIN entry/check, timed unlock, failed-attempt lockout and code
// re-programming while unlocked. All outputs are registered.
module safe_lock_controller
  import safe_pkg::*;
#(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned          LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned          ENTRY_TIMEOUT  = 250_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] key_code_i,
  output logic       unlock_o,
  output logic       lockout_o,
  output logic       alarm_o,
  output logic       prog_mode_o,
  output logic       ok_pulse_o,
  output logic       err_pulse_o,
  output logic [2:0] fail_count_o,
  output logic [2:0] state_dbg_o
);

  localparam int unsigned MaxUl     = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxUl > ENTRY_TIMEOUT) ? MaxUl : ENTRY_TIMEOUT;
  localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;
  localparam int unsigned CntW      = $clog2(CODE_LEN + 1);

  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [2:0]            fail_q, fail_d;
  logic [4*CODE_LEN-1:0] code_q, code_d;
  logic                  unlock_q, lockout_q, prog_q, ok_q, ok_d, err_q, err_d;

  logic                  buf_clr, buf_shift, key_acc;
  logic [4*CODE_LEN-1:0] buf_val;
  logic [CntW-1:0]       buf_cnt;
  logic                  buf_ovf;

  logic                  key_dig, key_enter, key_star;
  logic                  buf_full_ok, expired;
  logic [TimerW-1:0]     timer_last;
  logic [2:0]            fail_inc;

  keypad_entry_buffer #(
    .CODE_LEN(CODE_LEN)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (buf_clr),
    .shift_i   (buf_shift),
    .digit_i   (key_code_i),
    .buf_o     (buf_val),
    .count_o   (buf_cnt),
    .overflow_o(buf_ovf)
  );

  // Key decode, per-state timer limit and the "exactly CODE_LEN digits, no overflow" test.
  always_comb begin
    key_dig     = is_digit(key_code_i);
    key_enter   = (key_code_i == KEY_ENTER);
    key_star    = (key_code_i == KEY_STAR);
    buf_full_ok = (buf_cnt == CntW'(CODE_LEN)) && !buf_ovf;
    fail_inc    = fail_q + 3'd1;
    case (state_q)
      StUnlocked: timer_last = TimerW'(UNLOCK_CYCLES - 1);
      StLockout:  timer_last = TimerW'(LOCKOUT_CYCLES - 1);
      default:    timer_last = TimerW'(ENTRY_TIMEOUT - 1);
    endcase
    expired = (timer_q == timer_last);
  end

  // Next-state logic; a key always takes precedence over a same-cycle timer expiry.
  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    code_d    = code_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    buf_clr   = 1'b0;
    buf_shift = 1'b0;
    key_acc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_dig) begin
          buf_shift = 1'b1;
          state_d   = StEntry;
        end
      end
      StEntry: begin
        if (key_dig) begin
          buf_shift = 1'b1;
          key_acc   = 1'b1;
        end else if (key_star || (!key_enter && expired)) begin
          buf_clr = 1'b1;
          state_d = StIdle;
        end else if (key_enter) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        buf_clr = 1'b1;
        if (buf_full_ok && (buf_val == code_q)) begin
          ok_d    = 1'b1;
          fail_d  = 3'd0;
          state_d = StUnlocked;
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_inc;
          state_d = (fail_inc == 3'(MAX_TRIES)) ? StLockout : StIdle;
        end
      end
      StUnlocked: begin
        if (key_enter) begin
          state_d = StIdle;
        end else if (key_star) begin
          state_d = StProgram;
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      StProgram: begin
        if (key_dig) begin
          buf_shift = 1'b1;
          key_acc   = 1'b1;
        end else if (key_enter && buf_full_ok) begin
          buf_clr = 1'b1;
          code_d  = buf_val;
          ok_d    = 1'b1;
          state_d = StIdle;
        end else if (key_enter || key_star || expired) begin
          buf_clr = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (expired) begin
          fail_d  = 3'd0;
          state_d = StIdle;
        end
      end
      default: begin
        buf_clr = 1'b1;
        state_d = StIdle;
      end
    endcase

    // Timer restarts on any state change or accepted digit; idles at zero in IDLE.
    if ((state_d != state_q) || key_acc || (state_q == StIdle)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  // FSM state, timer, fail counter, stored code and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      fail_q    <= 3'd0;
      code_q    <= DEFAULT_CODE;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      prog_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      code_q    <= code_d;
      unlock_q  <= (state_d == StUnlocked);
      lockout_q <= (state_d == StLockout);
      prog_q    <= (state_d == StProgram);
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign unlock_o     = unlock_q;
  assign lockout_o    = lockout_q;
  assign alarm_o      = lockout_q;
  assign prog_mode_o  = prog_q;
  assign ok_pulse_o   = ok_q;
  assign err_pulse_o  = err_q;
  assign fail_count_o = fail_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_safe_lock_controller.sv
// Directed scenarios followed by randomized PIN/program transactions checked against a
// transaction-level model (stored code and consecutive-failure count).
module tb_safe_lock_controller;
  import safe_pkg::*;

  localparam int unsigned UC = 20;
  localparam int unsigned LC = 40;
  localparam int unsigned TC = 30;
  localparam int unsigned MT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       unlock, lockout, alarm, prog_mode, ok_pulse, err_pulse;
  logic [2:0] fail_count, state_dbg;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_code;
  int          m_fail;
  int          cnt;
  bit          saw_unlock;

  safe_lock_controller #(
    .CODE_LEN      (4),
    .DEFAULT_CODE  (16'h1234),
    .MAX_TRIES     (MT),
    .UNLOCK_CYCLES (UC),
    .LOCKOUT_CYCLES(LC),
    .ENTRY_TIMEOUT (TC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_code_i  (key),
    .unlock_o    (unlock),
    .lockout_o   (lockout),
    .alarm_o     (alarm),
    .prog_mode_o (prog_mode),
    .ok_pulse_o  (ok_pulse),
    .err_pulse_o (err_pulse),
    .fail_count_o(fail_count),
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    tick();
    key = KEY_NONE;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
  endtask

  // Enter a code that the model says is valid and confirm the unlock.
  task automatic unlock_with(input string tag, input logic [15:0] c);
    enter_code(c);
    press(KEY_ENTER);
    chk({tag, "_check_state"}, 32'(state_dbg), 32'd2);
    tick();
    chk({tag, "_ok"}, 32'(ok_pulse), 32'd1);
    chk({tag, "_unlock"}, 32'(unlock), 32'd1);
    chk({tag, "_fail0"}, 32'(fail_count), 32'd0);
  endtask

  // One random attempt: random digits (sometimes the right code), optional reprogram.
  task automatic rand_attempt();
    int          n;
    bit          use_code;
    logic [15:0] val;
    logic [15:0] nc;
    logic [3:0]  d;
    n        = $urandom_range(1, 5);
    use_code = ($urandom_range(0, 2) == 0);
    val      = '0;
    if (use_code) n = 4;
    for (int i = 0; i < n; i++) begin
      d = use_code ? m_code[15-4*i -: 4] : 4'($urandom_range(0, 9));
      if (i < 4) val = {val[11:0], d};
      press(d);
      repeat ($urandom_range(0, 5)) tick();
    end
    press(KEY_ENTER);
    tick();
    if (n == 4 && val == m_code) begin
      m_fail = 0;
      chk("r_ok", 32'(ok_pulse), 32'd1);
      chk("r_unlock", 32'(unlock), 32'd1);
      chk("r_fail", 32'(fail_count), 32'(m_fail));
      if ($urandom_range(0, 1) == 1) begin
        press(KEY_STAR);
        chk("r_prog", 32'(prog_mode), 32'd1);
        for (int i = 0; i < 4; i++) nc = {nc[11:0], 4'($urandom_range(0, 9))};
        enter_code(nc);
        press(KEY_ENTER);
        chk("r_commit_ok", 32'(ok_pulse), 32'd1);
        m_code = nc;
      end else begin
        press(KEY_ENTER);
        chk("r_relock", 32'(unlock), 32'd0);
      end
    end else begin
      m_fail++;
      chk("r_err", 32'(err_pulse), 32'd1);
      chk("r_fail", 32'(fail_count), 32'(m_fail));
      if (m_fail == int'(MT)) begin
        chk("r_lockout", 32'(lockout), 32'd1);
        repeat (LC) tick();
        m_fail = 0;
        chk("r_lockout_end", 32'(lockout), 32'd0);
        chk("r_fail_clr", 32'(fail_count), 32'd0);
      end
    end
    chk("r_idle", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    key   = KEY_NONE;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_unlock", 32'(unlock), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_prog", 32'(prog_mode), 32'd0);
    chk("rst_ok", 32'(ok_pulse), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Correct PIN: one-cycle ok pulse, unlock held for exactly UC cycles.
    unlock_with("pin1234", 16'h1234);
    cnt = 1;
    tick();
    chk("ok_one_cycle", 32'(ok_pulse), 32'd0);
    while (unlock && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("unlock_len", 32'(cnt), 32'(UC));
    chk("unlock_end_idle", 32'(state_dbg), 32'd0);

    // Three wrong PINs -> lockout; keys ignored throughout.
    for (int t = 1; t <= 3; t++) begin
      enter_code(16'h1235);
      press(KEY_ENTER);
      tick();
      chk("wrong_err", 32'(err_pulse), 32'd1);
      chk("wrong_ok", 32'(ok_pulse), 32'd0);
      chk("wrong_fail", 32'(fail_count), 32'(t));
    end
    chk("lock_state", 32'(state_dbg), 32'd5);
    chk("lock_lockout", 32'(lockout), 32'd1);
    chk("lock_alarm", 32'(alarm), 32'd1);
    cnt        = 1;
    saw_unlock = 1'b0;
    while (lockout && cnt < 200) begin
      key = 4'($urandom_range(0, 15));
      tick();
      if (unlock) saw_unlock = 1'b1;
      if (lockout) cnt++;
    end
    key = KEY_NONE;
    chk("lock_len", 32'(cnt), 32'(LC));
    chk("lock_keys_ignored", 32'(saw_unlock), 32'd0);
    chk("lock_fail_clr", 32'(fail_count), 32'd0);
    chk("lock_end_idle", 32'(state_dbg), 32'd0);

    // Overflowed entry fails; the right code afterwards clears the failure count.
    enter_code(16'h1234);
    press(4'd9);
    press(KEY_ENTER);
    tick();
    chk("ovf_err", 32'(err_pulse), 32'd1);
    chk("ovf_fail", 32'(fail_count), 32'd1);
    unlock_with("after_ovf", 16'h1234);
    press(KEY_ENTER);
    chk("relock_unlock", 32'(unlock), 32'd0);
    chk("relock_state", 32'(state_dbg), 32'd0);

    // Partial entry times out; star aborts without error.
    press(4'd1);
    press(4'd2);
    repeat (TC - 1) tick();
    chk("timeout_pre", 32'(state_dbg), 32'd1);
    tick();
    chk("timeout_idle", 32'(state_dbg), 32'd0);
    chk("timeout_fail", 32'(fail_count), 32'd0);
    press(4'd1);
    press(4'd2);
    press(KEY_STAR);
    chk("star_idle", 32'(state_dbg), 32'd0);
    chk("star_no_err", 32'(err_pulse), 32'd0);

    // Reprogram to 5678 and confirm old/new codes.
    unlock_with("prog_unlock", 16'h1234);
    press(KEY_STAR);
    chk("prog_state", 32'(state_dbg), 32'd4);
    chk("prog_mode", 32'(prog_mode), 32'd1);
    chk("prog_unlock_drop", 32'(unlock), 32'd0);
    enter_code(16'h5678);
    press(KEY_ENTER);
    chk("prog_ok", 32'(ok_pulse), 32'd1);
    chk("prog_idle", 32'(state_dbg), 32'd0);
    enter_code(16'h1234);
    press(KEY_ENTER);
    tick();
    chk("old_code_err", 32'(err_pulse), 32'd1);
    unlock_with("new_code", 16'h5678);
    press(KEY_ENTER);
    press(4'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_state", 32'(state_dbg), 32'd0);
    unlock_with("default_back", 16'h1234);

    // Short program is rejected and code stays 1234.
    press(KEY_STAR);
    press(4'd5);
    press(4'd6);
    press(KEY_ENTER);
    chk("short_prog_err", 32'(err_pulse), 32'd1);
    chk("short_prog_ok", 32'(ok_pulse), 32'd0);
    unlock_with("code_kept", 16'h1234);
    press(KEY_ENTER);

    // Randomized transactions against the model.
    m_code = 16'h1234;
    m_fail = 0;
    for (int t = 0; t < 40; t++) rand_attempt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
